// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO.
// Register window: TXDATA (push), STATUS, DIVISOR (clocks per bit), reserved.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR       = 32'h0001_0000,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned DEFAULT_DIVISOR = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  output logic [31:0] read_data,
  input  logic [31:0] write_data,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [3:0]  byte_enable,
  output logic        tx
);

  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam logic [4:0]  DepthCnt = 5'(FIFO_DEPTH);
  localparam logic [15:0] DivReset = 16'(DEFAULT_DIVISOR);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]      count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     div_q, div_d;
  logic [15:0]     bit_div_q, bit_div_d;
  logic [15:0]     tick_q, tick_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      data_q, data_d;
  logic            tx_q, tx_d;

  logic        sel, wr_sel;
  logic [1:0]  offset;
  logic        push_req, push, pop;
  logic        empty, full, busy;
  logic        last_tick;
  logic [2:0]  bit_idx_nxt;
  logic [15:0] div_new;
  logic [31:0] status;
  logic        unused_bits;

  assign unused_bits = ^{address[1:0], write_data[31:16], byte_enable[3:2]};

  assign sel      = (address[31:4] == BASE_ADDR[31:4]);
  assign offset   = address[3:2];
  assign wr_sel   = write_enable & sel;
  assign empty    = (count_q == 5'd0);
  assign full     = (count_q == DepthCnt);
  assign busy     = (state_q != StIdle);
  assign push_req = wr_sel & (offset == 2'd0) & byte_enable[0];
  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign push     = push_req & (~full | pop);

  assign last_tick   = (tick_q == bit_div_q - 16'd1);
  assign bit_idx_nxt = bit_idx_q + 3'd1;

  // Transmit FSM: each START, DATA bit and STOP lasts bit_div_q clocks.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    bit_div_d = bit_div_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop       = 1'b1;
          state_d   = StStart;
          tx_d      = 1'b0;
          tick_d    = 16'd0;
          data_d    = fifo_q[rd_ptr_q];
          bit_div_d = div_q;
        end
      end
      StStart: begin
        if (last_tick) begin
          state_d   = StData;
          tick_d    = 16'd0;
          bit_idx_d = 3'd0;
          tx_d      = data_q[0];
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end
      StData: begin
        if (last_tick) begin
          tick_d = 16'd0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_nxt;
            tx_d      = data_q[bit_idx_nxt];
          end
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end
      StStop: begin
        if (last_tick) begin
          tick_d = 16'd0;
          if (!empty) begin
            pop       = 1'b1;
            state_d   = StStart;
            tx_d      = 1'b0;
            data_d    = fifo_q[rd_ptr_q];
            bit_div_d = div_q;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO bookkeeping, overflow flag and divisor register.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    div_d    = div_q;
    div_new  = div_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    count_d = count_q + {4'd0, push} - {4'd0, pop};

    if (push_req && full && !pop) begin
      ovf_d = 1'b1;
    end else if (wr_sel && (offset == 2'd1) && byte_enable[0] && write_data[3]) begin
      ovf_d = 1'b0;
    end

    if (wr_sel && (offset == 2'd2) && (byte_enable[1:0] != 2'b00)) begin
      if (byte_enable[0]) div_new[7:0]  = write_data[7:0];
      if (byte_enable[1]) div_new[15:8] = write_data[15:8];
      div_d = (div_new == 16'd0) ? 16'd1 : div_new;
    end
  end

  always_comb begin
    status    = {23'd0, count_q, ovf_q, empty, full, busy};
    read_data = 32'd0;
    if (read_enable && sel) begin
      unique case (offset)
        2'd1:    read_data = status;
        2'd2:    read_data = {16'd0, div_q};
        default: read_data = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= write_data[7:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= 5'd0;
      ovf_q     <= 1'b0;
      div_q     <= DivReset;
      bit_div_q <= 16'd1;
      tick_q    <= 16'd0;
      bit_idx_q <= 3'd0;
      data_q    <= 8'd0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      div_q     <= div_d;
      bit_div_q <= bit_div_d;
      tick_q    <= tick_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a line-level UART receiver decodes tx against an expected byte
// queue and divisor; directed steps cover latency, FIFO full/overflow, divisor and reset.
module tb_mmio_uart_tx;

  localparam logic [31:0] Base    = 32'h0001_0000;
  localparam logic [31:0] AStatus = Base + 32'h4;
  localparam logic [31:0] ADiv    = Base + 32'h8;
  localparam logic [31:0] ARsvd   = Base + 32'hC;

  logic        clock, reset, read_enable, write_enable, tx;
  logic [31:0] address, read_data, write_data;
  logic [3:0]  byte_enable;

  mmio_uart_tx #(
    .BASE_ADDR      (Base),
    .FIFO_DEPTH     (8),
    .DEFAULT_DIVISOR(16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .read_data   (read_data),
    .write_data  (write_data),
    .read_enable (read_enable),
    .write_enable(write_enable),
    .byte_enable (byte_enable),
    .tx          (tx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] exp_b;
    int         bad;
    int         start;
    int         last;
    int         div;
  } frame_t;

  frame_t      recs[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  sent[$];
  logic [15:0] exp_div = 16'd16;
  bit          mon_en = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          wr_cyc;

  // Receiver: frame = 1 start slot, 8 data slots LSB first, 1 stop slot, div clocks each.
  bit         m_active = 1'b0;
  logic       m_prev = 1'b1;
  int         m_c, slot, off;
  logic       lvl;
  logic [2:0] bi;
  frame_t     m_f;

  always @(negedge clock) begin
    if (!mon_en || reset !== 1'b1) begin
      m_active = 1'b0;
      m_prev   = 1'b1;
    end else begin
      if (!m_active && m_prev === 1'b1 && tx === 1'b0) begin
        m_active  = 1'b1;
        m_c       = 0;
        m_f.bad   = 0;
        m_f.rx    = 8'h00;
        m_f.div   = int'(exp_div);
        m_f.start = cyc;
        m_f.exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      end
      if (m_active) begin
        slot = m_c / m_f.div;
        off  = m_c % m_f.div;
        bi   = 3'(slot - 1);
        if (slot == 0)      lvl = 1'b0;
        else if (slot == 9) lvl = 1'b1;
        else                lvl = m_f.exp_b[bi];
        if (tx !== lvl) m_f.bad++;
        if (slot >= 1 && slot <= 8 && off == m_f.div / 2) m_f.rx[bi] = tx;
        if (m_c == 10 * m_f.div - 1) begin
          m_f.last = cyc;
          recs.push_back(m_f);
          m_active = 1'b0;
        end
        m_c++;
      end
      m_prev = tx;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge clock);
    address      = addr;
    write_data   = data;
    byte_enable  = be;
    write_enable = 1'b1;
    @(posedge clock);
    #1;
    wr_cyc       = cyc;
    write_enable = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] addr, input logic re, output logic [31:0] data);
    address     = addr;
    read_enable = re;
    #1;
    data        = read_data;
    read_enable = 1'b0;
  endtask

  task automatic rd_now(input string tag, input logic [31:0] addr, input logic [31:0] exp_v);
    logic [31:0] v;
    bus_rd(addr, 1'b1, v);
    check(tag, v, exp_v);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp_v);
    @(negedge clock);
    rd_now(tag, addr, exp_v);
  endtask

  task automatic wait_at(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accept);
    bus_wr(Base, {24'($urandom), b}, 4'b0001);
    if (accept) exp_q.push_back(b);
  endtask

  task automatic wr_div(input logic [31:0] data, input logic [3:0] be);
    logic [15:0] m;
    m = exp_div;
    if (be[0]) m[7:0] = data[7:0];
    if (be[1]) m[15:8] = data[15:8];
    if (be[1:0] != 2'b00 && m == 16'd0) m = 16'd1;
    bus_wr(ADiv, data, be);
    exp_div = m;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t;
    t = 0;
    while (recs.size() < n && t < budget) begin
      @(negedge clock);
      t++;
    end
    check("frame_count", 32'(recs.size()), 32'(n));
  endtask

  task automatic next_frame(input logic [7:0] b, output int s, output int l);
    frame_t f;
    s = 0;
    l = 0;
    check("frame_present", 32'(recs.size() != 0), 32'd1);
    if (recs.size() != 0) begin
      f = recs.pop_front();
      check("frame_data", {24'd0, f.rx}, {24'd0, b});
      check("frame_shape_errs", 32'(f.bad), 32'd0);
      s = f.start;
      l = f.last;
    end
  endtask

  logic [31:0] rv;
  logic [7:0]  b;
  int          e0, s, l, l_prev, d, n, sa;

  initial begin
    reset        = 1'b0;
    address      = 32'd0;
    write_data   = 32'd0;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    byte_enable  = 4'd0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_tx", {31'd0, tx}, 32'd1);
    rd_now("rst_status", AStatus, 32'h4);
    reset  = 1'b1;
    mon_en = 1'b1;
    rd_chk("rst_div", ADiv, 32'd16);
    rd_chk("txdata_reads_0", Base, 32'd0);
    repeat (20) @(negedge clock);
    check("rst_no_frame", 32'(recs.size()), 32'd0);

    // Single 0x55 frame at DIVISOR=16: latency, shape, busy window
    push_byte(8'h55, 1'b1);
    e0 = wr_cyc;
    wait_at(e0 + 10);
    rd_now("t1_busy_mid", AStatus, 32'h5);
    wait_at(e0 + 160);
    rd_now("t1_busy_last", AStatus, 32'h5);
    wait_at(e0 + 161);
    rd_now("t1_idle_after", AStatus, 32'h4);
    wait_frames(1, 50);
    next_frame(8'h55, s, l);
    check("t1_latency", 32'(s - e0), 32'd1);

    // Nine consecutive writes at DIVISOR=4: all accepted, back-to-back frames
    wr_div(32'd4, 4'b0011);
    for (int k = 0; k < 9; k++) begin
      b = 8'($urandom);
      sent.push_back(b);
      push_byte(b, 1'b1);
      if (k == 0) e0 = wr_cyc;
    end
    rd_chk("t2_status_full", AStatus, 32'h83);
    wait_frames(9, 9 * 40 + 60);
    for (int k = 0; k < 9; k++) begin
      next_frame(sent[k], s, l);
      if (k == 0) check("t2_latency", 32'(s - e0), 32'd1);
      else        check("t2_gap", 32'(s - l_prev), 32'd1);
      l_prev = l;
    end
    sent.delete();

    // Overflow while blocked mid-frame, W1C, push accepted on the pop cycle
    wr_div(32'd16, 4'b0011);
    b = 8'($urandom);
    sent.push_back(b);
    push_byte(b, 1'b1);
    e0 = wr_cyc;
    repeat (5) @(negedge clock);
    for (int k = 0; k < 10; k++) begin
      b = 8'($urandom);
      if (k < 8) sent.push_back(b);
      push_byte(b, k < 8);
    end
    rd_chk("t3_overflow", AStatus, 32'h8B);
    bus_wr(AStatus, 32'h0000_0008, 4'b1110);
    rd_chk("t3_w1c_no_lane", AStatus, 32'h8B);
    bus_wr(AStatus, 32'hFFFF_FFFF, 4'b0001);
    rd_chk("t3_w1c_clear", AStatus, 32'h83);
    wait_at(e0 + 159);
    b = 8'($urandom);
    sent.push_back(b);
    push_byte(b, 1'b1);
    rd_chk("t3_push_on_pop", AStatus, 32'h83);
    wait_frames(10, 10 * 160 + 200);
    for (int k = 0; k < 10; k++) begin
      next_frame(sent[k], s, l);
      if (k > 0) check("t3_gap", 32'(s - l_prev), 32'd1);
      l_prev = l;
    end
    sent.delete();

    // DIVISOR zero clamp, per-lane write, mid-frame change
    wr_div(32'd0, 4'b0011);
    rd_chk("t4_div_zero", ADiv, 32'd1);
    wr_div(32'hABCD_1200, 4'b0010);
    rd_chk("t4_div_lane1", ADiv, 32'h1201);
    wr_div(32'd16, 4'b0011);
    push_byte(8'hA5, 1'b1);
    e0 = wr_cyc;
    push_byte(8'h0F, 1'b1);
    wait_at(e0 + 50);
    wr_div(32'd8, 4'b0011);
    rd_chk("t4_div_now8", ADiv, 32'd8);
    wait_frames(2, 400);
    next_frame(8'hA5, sa, l);
    check("t4_first_len16", 32'(sa - e0), 32'd1);
    next_frame(8'h0F, s, l_prev);
    check("t4_second_start", 32'(s - sa), 32'd160);

    // Randomised rounds
    for (int r = 0; r < 3; r++) begin
      d = int'($urandom_range(6, 1));
      n = int'($urandom_range(9, 1));
      wr_div(32'(d), 4'b0011);
      repeat (2) @(negedge clock);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        sent.push_back(b);
        push_byte(b, 1'b1);
        if (k == 0) e0 = wr_cyc;
      end
      wait_frames(n, n * 10 * d + 60);
      for (int k = 0; k < n; k++) begin
        next_frame(sent[k], s, l);
        if (k == 0) check("rand_latency", 32'(s - e0), 32'd1);
        else        check("rand_gap", 32'(s - l_prev), 32'd1);
        l_prev = l;
      end
      sent.delete();
      repeat (3) @(negedge clock);
      rd_now("rand_idle_status", AStatus, 32'h4);
    end

    // Unselected and reserved accesses
    rd_chk("unsel_rd_20", Base + 32'h20, 32'd0);
    rd_chk("unsel_rd_24", Base + 32'h24, 32'd0);
    rd_chk("unsel_rd_28", Base + 32'h28, 32'd0);
    rd_chk("rsvd_rd", ARsvd, 32'd0);
    @(negedge clock);
    bus_rd(AStatus, 1'b0, rv);
    check("no_read_enable", rv, 32'd0);
    bus_wr(Base + 32'h20, 32'h41, 4'hF);
    bus_wr(Base + 32'h28, 32'h3, 4'hF);
    bus_wr(ARsvd, 32'hFFFF_FFFF, 4'hF);
    bus_wr(Base, 32'h77, 4'b1110);
    repeat (30) @(negedge clock);
    check("unsel_no_frame", 32'(recs.size()), 32'd0);
    rd_now("unsel_status", AStatus, 32'h4);
    rd_chk("unsel_div", ADiv, {16'd0, exp_div});

    // Reset during DATA bit 3 at DIVISOR=12
    wr_div(32'd12, 4'b0011);
    push_byte(8'hF0, 1'b1);
    e0 = wr_cyc;
    push_byte(8'h3C, 1'b1);
    wait_at(e0 + 54);
    check("t7_tx_before", {31'd0, tx}, 32'd0);
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    check("t7_tx_async", {31'd0, tx}, 32'd1);
    rd_now("t7_status", AStatus, 32'h4);
    rd_now("t7_div", ADiv, 32'd16);
    repeat (2) @(negedge clock);
    reset   = 1'b1;
    exp_q.delete();
    exp_div = 16'd16;
    mon_en  = 1'b1;
    repeat (40) @(negedge clock);
    check("t7_no_frame", 32'(recs.size()), 32'd0);
    check("t7_tx_idle", {31'd0, tx}, 32'd1);
    push_byte(8'h3C, 1'b1);
    wait_frames(1, 250);
    next_frame(8'h3C, s, l);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
